// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor controller.
package serial_subtractor_pkg;

  localparam int SUB_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

endpackage

// File: rtl/serial_subtractor_controller_cell.sv
// One-bit full subtractor used by the serial datapath (a - b - bin).
module full_subtractor_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor_controller.sv
// Bit-serial subtractor, LSB first, one bit per clock; result is WIDTH cycles after start.
// Optional two's-complement overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
//
// state | meaning
// IDLE  | waiting for Start_In; operands latched on accept
// SHIFT | one bit processed per edge, WIDTH edges total
// DONE  | one-cycle result-valid pulse, then back to IDLE
module serial_subtractor_controller
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
  input  logic             Clock_In,
  input  logic             Reset_In,
  input  logic             Start_In,
  input  logic [WIDTH-1:0] Data_A_In,
  input  logic [WIDTH-1:0] Data_B_In,
  output logic             Busy_Out,
  output logic             Done_Out,
  output logic [WIDTH-1:0] Difference_Out,
  output logic             Borrow_Out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             Overflow_Out
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sub_state_e       state, state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] bit_cnt;
  logic             borrow_q;
  logic             cell_diff;
  logic             cell_bout;
  logic             last_bit;

  assign last_bit = (bit_cnt == CNT_LAST);

  full_subtractor_cell u_cell (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (borrow_q),
    .diff (cell_diff),
    .bout (cell_bout)
  );

  always_ff @(posedge Clock_In) begin
    if (Reset_In) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start_In) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The minuend register doubles as the result register: each consumed
  // A bit at the bottom is replaced by its difference bit at the top.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      a_sh           <= '0;
      b_sh           <= '0;
      bit_cnt        <= '0;
      borrow_q       <= 1'b0;
      Difference_Out <= '0;
      Borrow_Out     <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      Overflow_Out   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start_In) begin
            a_sh     <= Data_A_In;
            b_sh     <= Data_B_In;
            bit_cnt  <= '0;
            borrow_q <= 1'b0;
          end
        end
        SHIFT: begin
          a_sh     <= {cell_diff, a_sh[WIDTH-1:1]};
          b_sh     <= {1'b0, b_sh[WIDTH-1:1]};
          bit_cnt  <= bit_cnt + 1'b1;
          borrow_q <= cell_bout;
          if (last_bit) begin
            Difference_Out <= {cell_diff, a_sh[WIDTH-1:1]};
            Borrow_Out     <= cell_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
            // On the last bit a_sh[0]/b_sh[0] are the operand sign bits.
            Overflow_Out   <= (a_sh[0] != b_sh[0]) && (cell_diff != a_sh[0]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy_Out = (state == SHIFT);
  assign Done_Out = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_controller.sv
// Directed self-checking bench for serial_subtractor_controller (WIDTH=8).
module tb_serial_subtractor_controller;

  localparam int W = 8;

  logic         Clock_In = 1'b0;
  logic         Reset_In;
  logic         Start_In;
  logic [W-1:0] Data_A_In;
  logic [W-1:0] Data_B_In;
  logic         Busy_Out;
  logic         Done_Out;
  logic [W-1:0] Difference_Out;
  logic         Borrow_Out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         Overflow_Out;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] held_d;
  logic         held_b;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         borrow;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  always #5 Clock_In = ~Clock_In;

  serial_subtractor_controller #(.WIDTH(W)) dut (
    .Clock_In       (Clock_In),
    .Reset_In       (Reset_In),
    .Start_In       (Start_In),
    .Data_A_In      (Data_A_In),
    .Data_B_In      (Data_B_In),
    .Busy_Out       (Busy_Out),
    .Done_Out       (Done_Out),
    .Difference_Out (Difference_Out),
    .Borrow_Out     (Borrow_Out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .Overflow_Out   (Overflow_Out)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    Data_A_In = a;
    Data_B_In = b;
    Start_In  = 1'b1;
    @(negedge Clock_In);
    Start_In  = 1'b0;
  endtask

  // Counts Busy cycles (bounded) and watches that the outputs hold meanwhile.
  task automatic wait_done(input int pre, output int busy_total, output bit hold_ok);
    int n;
    n = 0;
    busy_total = pre;
    hold_ok = 1'b1;
    while (Busy_Out && n < 40) begin
      busy_total++;
      n++;
      if (Difference_Out !== held_d || Borrow_Out !== held_b) hold_ok = 1'b0;
      @(negedge Clock_In);
    end
  endtask

  task automatic finish_op(input vec_t v, input int bt, input bit hok, input string tag);
    check({tag, " busy_cycles"}, 32'(bt), 32'd8);
    check({tag, " hold_during_shift"}, 32'(hok), 32'd1);
    check({tag, " done_pulse"}, 32'(Done_Out), 32'd1);
    check({tag, " difference"}, 32'(Difference_Out), 32'(v.d));
    check({tag, " borrow"}, 32'(Borrow_Out), 32'(v.borrow));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, " overflow"}, 32'(Overflow_Out), 32'(v.ovf));
`endif
    held_d = v.d;
    held_b = v.borrow;
    @(negedge Clock_In);
    check({tag, " done_single"}, 32'(Done_Out), 32'd0);
    check({tag, " idle_after"}, 32'(Busy_Out), 32'd0);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int bt;
    bit hok;
    start_op(v.a, v.b);
    wait_done(0, bt, hok);
    finish_op(v, bt, hok, tag);
  endtask

  initial begin
    vec_t v;
    int   bt;
    bit   hok;
    bit   saw_done;
    bit   vals_ok;
    int   ndone;
    int   pos[3];

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'hAA, 8'h55, 8'h55, 1'b0, 1'b1};

    Reset_In  = 1'b1;
    Start_In  = 1'b0;
    Data_A_In = '0;
    Data_B_In = '0;
    held_d    = '0;
    held_b    = 1'b0;
    repeat (2) @(negedge Clock_In);
    check("reset busy", 32'(Busy_Out), 32'd0);
    check("reset done", 32'(Done_Out), 32'd0);
    check("reset difference", 32'(Difference_Out), 32'd0);
    check("reset borrow", 32'(Borrow_Out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("reset overflow", 32'(Overflow_Out), 32'd0);
`endif
    Reset_In = 1'b0;
    @(negedge Clock_In);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulse 3 cycles into SHIFT with different operands must be ignored.
    start_op(8'h0A, 8'h04);
    repeat (2) @(negedge Clock_In);
    Data_A_In = 8'h01;
    Data_B_In = 8'h09;
    Start_In  = 1'b1;
    @(negedge Clock_In);
    Start_In  = 1'b0;
    wait_done(3, bt, hok);
    v = '{8'h0A, 8'h04, 8'h06, 1'b0, 1'b0};
    finish_op(v, bt, hok, "ignore_start");
    @(negedge Clock_In);
    check("ignore_start no_queued_op", 32'(Busy_Out), 32'd0);

    // Reset 4 cycles into SHIFT aborts without a Done pulse.
    start_op(8'h33, 8'h11);
    repeat (3) @(negedge Clock_In);
    Reset_In = 1'b1;
    @(negedge Clock_In);
    check("abort busy", 32'(Busy_Out), 32'd0);
    check("abort done", 32'(Done_Out), 32'd0);
    check("abort difference", 32'(Difference_Out), 32'd0);
    check("abort borrow", 32'(Borrow_Out), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("abort overflow", 32'(Overflow_Out), 32'd0);
`endif
    Reset_In = 1'b0;
    held_d   = '0;
    held_b   = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge Clock_In);
      if (Done_Out) saw_done = 1'b1;
    end
    check("abort no_done", 32'(saw_done), 32'd0);
    v = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    run_op(v, "after_abort");

    // Start held high: back-to-back ops, Done every 10 cycles.
    Data_A_In = 8'h10;
    Data_B_In = 8'h20;
    Start_In  = 1'b1;
    ndone     = 0;
    vals_ok   = 1'b1;
    pos       = '{0, 0, 0};
    for (int i = 1; i <= 30; i++) begin
      @(negedge Clock_In);
      if (Done_Out) begin
        if (ndone < 3) pos[ndone] = i;
        ndone++;
        if (Difference_Out !== 8'hF0 || Borrow_Out !== 1'b1) vals_ok = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
        if (Overflow_Out !== 1'b0) vals_ok = 1'b0;
`endif
      end
    end
    Start_In = 1'b0;
    check("held done_count", 32'(ndone), 32'd3);
    check("held done_pos0", 32'(pos[0]), 32'd9);
    check("held done_pos1", 32'(pos[1]), 32'd19);
    check("held done_pos2", 32'(pos[2]), 32'd29);
    check("held results", 32'(vals_ok), 32'd1);
    @(negedge Clock_In);
    check("held released idle", 32'(Busy_Out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor_controller.md
SERIAL_SUBTRACTOR_CONTROLLER -- requirements
Module: serial_subtractor_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result bit count (legal range 2..32).
REQ-002 SHALL have port Clock_In  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset_In  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port Start_In  input  1  request to begin a subtraction Data_A_In - Data_B_In.
REQ-005 SHALL have port Data_A_In  input  WIDTH  minuend, sampled only on an accepted start.
REQ-006 SHALL have port Data_B_In  input  WIDTH  subtrahend, sampled only on an accepted start.
REQ-007 SHALL have port Busy_Out  output  1  high while an operation is in progress (state SHIFT).
REQ-008 SHALL have port Done_Out  output  1  single-cycle pulse marking result valid.
REQ-009 SHALL have port Difference_Out  output  WIDTH  result, modulo 2^WIDTH.
REQ-010 SHALL have port Borrow_Out  output  1  final borrow; high when unsigned A < B.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; encoding from the shared package.
REQ-012 IDLE: Start_In high at edge -> latch A/B into shift registers, clear bit counter and borrow flop, go to SHIFT.
REQ-013 SHIFT: each edge processes one bit LSB-first via a full-subtractor cell (diff = a^b^bin; bout = (~a&b)|(~(a^b)&bin)), shifts diff into result register, registers bout.
REQ-014 SHIFT SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1 -> DONE, Difference_Out and Borrow_Out updated.
REQ-015 DONE SHALL last one cycle with Done_Out=1, then -> IDLE unconditionally.
REQ-016 Latency: Start accepted at edge k -> Done_Out high in the cycle after edge k+WIDTH.
REQ-017 Start_In while in SHIFT or DONE SHALL be ignored (no queueing, no operand update).
REQ-018 Start_In held high continuously SHALL start a new operation on the first IDLE edge following DONE.
REQ-019 Difference_Out/Borrow_Out SHALL hold their last result until the next DONE; not altered during SHIFT.
REQ-020 Busy_Out SHALL equal (state==SHIFT); Done_Out SHALL equal (state==DONE); both registered-state decodes, no combinational path from inputs.

Reset
REQ-021 Reset_In high at an edge SHALL force IDLE, counter 0, borrow flop 0, Difference_Out 0, Borrow_Out 0, Busy_Out 0, Done_Out 0.
REQ-022 Reset SHALL take priority over Start_In and abort an in-flight operation without emitting Done_Out.

Configuration
REQ-023 Macro SERIAL_SUB_OVERFLOW_EN, when defined, SHALL add port Overflow_Out  output  1, registered with Difference_Out, = (A[msb]!=B[msb]) & (D[msb]!=A[msb]) (two's-complement overflow), reset 0.
REQ-024 Without SERIAL_SUB_OVERFLOW_EN the port and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-025 Package serial_subtractor_pkg SHALL hold the state enum typedef (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-026 The per-bit cell SHALL be a sub-module full_subtractor_cell (inputs a, b, bin; outputs diff, bout), instantiated once.
REQ-027 Counter width SHALL be $clog2(WIDTH)+1 bits.

Verification (WIDTH=8)
REQ-028 Reset, then Start with A=0x05, B=0x03 -> Busy 8 cycles, Done pulse 1 cycle, Difference 0x02, Borrow 0.
REQ-029 A=0x03, B=0x05 -> Difference 0xFE, Borrow 1; with SERIAL_SUB_OVERFLOW_EN Overflow 0.
REQ-030 A=0x80, B=0x01 -> Difference 0x7F, Borrow 0, Overflow 1 (macro defined); A=0x00, B=0x00 -> 0x00, Borrow 0.
REQ-031 Start pulsed again 3 cycles into SHIFT with new operands -> ignored; result of first operation, single Done.
REQ-032 Reset asserted 4 cycles into SHIFT -> next cycle all outputs 0, no Done; fresh Start A=0xFF, B=0xFF -> 0x00, Borrow 0.
REQ-033 Start held high 30 cycles, A=0x10, B=0x20 -> back-to-back ops, Done every 10 cycles, each Difference 0xF0, Borrow 1.
